tff_stream_decoder: RTL and testbench
=====================================

Name: tff_stream_decoder

Overview:
- Receive-side counterpart of the toggle-flop line driver, which changes its `q` level for every `t=1`.
- Recovers the original `t` bit stream from the sampled line level: decoded bit = current level XOR previous level.
- Hunts for a sync byte, then deserializes a fixed-length frame of words LSB-first.
- Presents each word on a valid/ready output port. Sits between the line sampler and the word-level consumer logic.

Parameters:
- DATA_W, 8, width of each output word in bits (≥2).
- SYNC_PAT, 8'h7E, 8-bit decoded-bit pattern that opens a frame; the first received bit ends up in bit 7.
- FRAME_WORDS, 4, number of words collected after sync before returning to hunt (≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- line_q  in  1  sampled line level (the toggle-flop `q` output).
- bit_en  in  1  one-cycle strobe: sample line_q this cycle; at most one per bit time.
- out_ready  in  1  consumer accepts data_out when high with data_out_valid.
- data_out  out  DATA_W  decoded word; bit 0 is the first bit received.
- data_out_valid  out  1  data_out holds an unconsumed word.
- sync_locked  out  1  high while in DATA state.
- overrun  out  1  one-cycle pulse: a completed word was dropped.
- frame_done  out  1  one-cycle pulse when the last word of a frame is captured.

Behaviour:
- Reset (async assert, sync release): all outputs 0, prev_level=0 (matches driver reset q=0), shift/bit counters 0, state HUNT.
- Decode: on bit_en, dbit = line_q ^ prev_level; prev_level <= line_q. With bit_en=0, nothing changes except handshake clearing.
- HUNT state:
  - On each bit_en, sync_sr <= {sync_sr[6:0], dbit}.
  - If the new sync_sr value equals SYNC_PAT, go to DATA in the next cycle, clear bit_cnt and word_cnt, and assert sync_locked.
  - sync_sr itself is not cleared on reset release; only its reset value is 0.
- DATA state:
  - On each bit_en, word_sr <= {dbit, word_sr[DATA_W-1:1]} (LSB-first) and bit_cnt increments.
  - When bit_cnt reaches DATA_W-1 and bit_en is high, the word completes.
  - Completion timing: data_out/data_out_valid update the cycle after the completing bit_en (latency 1 clk); bit_cnt wraps to 0.
  - On completion, word_cnt increments. If word_cnt == FRAME_WORDS-1: pulse frame_done, go to HUNT, clear sync_sr and sync_locked. The same cycle in which data_out_valid rises.
- Output handshake (one-entry holding register):
  - A transfer occurs on a cycle with data_out_valid & out_ready.
  - data_out is stable while valid and not ready.
  - If a word completes while data_out_valid=1 and out_ready=0: the new word is discarded, overrun pulses, the old word is retained, and word_cnt still advances.
  - If it completes on the same cycle that out_ready accepts the old word: the new word loads, valid stays 1, and there is no overrun.
- Continuous sync_sr shifting happens only in HUNT; there is no sync search mid-frame.
- reset_n asserted mid-frame: immediate return to the reset values; the partial word is lost; no frame_done.
- bit_en held high for several cycles: each cycle counts as a bit; it is the upstream's job to strobe.

Decomposition:
- Package tff_stream_pkg holds:
  - the state enum (HUNT, DATA);
  - default constants SYNC_DEFAULT=8'h7E and the DATA_W default;
  - a counter-width function, clog2-based, for bit_cnt and word_cnt.
- One natural sub-module, tff_bit_decoder: holds prev_level and emits dbit/dbit_valid. The framer/deserializer plus the output register stay in the top.

Test Plan:
- Reset: reset_n=0 with random line_q/bit_en toggling -> all outputs 0. Release, keep line_q constant with strobes -> decoded 0s, stays HUNT, sync_locked=0.
- Sync + word: drive toggles encoding bits 0,1,1,1,1,1,1,0 (8'h7E) then data 8'hA5 LSB-first, out_ready=1 -> sync_locked rises 1 clk after last sync bit; data_out=8'hA5 with valid 1 clk after the 8th data strobe.
- Full frame: sync then words 01,02,03,04 with out_ready=1 -> four valid transfers in order; frame_done pulses with word 04; sync_locked=0 afterwards.
- Backpressure: out_ready=0 during frame words 11,22 -> data_out holds 11, overrun pulses once when 22 completes. Raise out_ready -> 11 accepted; 33 is next.
- Simultaneous accept/complete: out_ready asserted exactly in the cycle the next word completes -> no overrun, data_out switches to the new word, valid stays 1.
- Mid-frame reset: assert reset_n=0 after 3 data bits of word 2 -> outputs cleared immediately. Resend sync+frame -> words received correctly from word 1.

Source files
------------

// File: rtl/tff_stream_pkg.sv
// Shared types and defaults for the toggle-flop stream decoder.
// The counter-width helper sizes counters that only need to reach n-1.
package tff_stream_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT        = 8'h7E;
    localparam int         DATA_W_DEFAULT      = 8;
    localparam int         FRAME_WORDS_DEFAULT = 4;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tff_stream_decoder_if.sv
// Line-side inputs plus the word-side valid/ready port of the stream decoder.
// The slave modport is the decoder's view; master is the surrounding logic.
interface tff_stream_decoder_if
    import tff_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic              line_q;
    logic              bit_en;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              sync_locked;
    logic              overrun;
    logic              frame_done;

    modport master (
        output line_q, bit_en, out_ready,
        input  data_out, data_out_valid, sync_locked, overrun, frame_done
    );

    modport slave (
        input  line_q, bit_en, out_ready,
        output data_out, data_out_valid, sync_locked, overrun, frame_done
    );

endinterface

// File: rtl/tff_bit_decoder.sv
// Recovers the toggle bit stream: a bit is 1 whenever the sampled level
// differs from the level seen at the previous strobe.
module tff_bit_decoder (
    input  logic clk,
    input  logic reset_n,
    input  logic line_q,
    input  logic bit_en,
    output logic dbit,
    output logic dbit_valid
);

    logic prev_level;

    // Reset level 0 matches the transmitting toggle flop's reset state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_level <= 1'b0;
        end else if (bit_en) begin
            prev_level <= line_q;
        end
    end

    assign dbit       = line_q ^ prev_level;
    assign dbit_valid = bit_en;

endmodule

// File: rtl/tff_stream_decoder.sv
// Toggle-flop line receiver: hunts for a sync byte, deserializes a frame of
// LSB-first words and offers each through a one-entry valid/ready register.
module tff_stream_decoder
    import tff_stream_pkg::*;
#(
    parameter int         DATA_W      = DATA_W_DEFAULT,
    parameter logic [7:0] SYNC_PAT    = SYNC_DEFAULT,
    parameter int         FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
    input logic                 clk,
    input logic                 reset_n,
    tff_stream_decoder_if.slave bus
);

    localparam int BW = cnt_width(DATA_W);
    localparam int WW = cnt_width(FRAME_WORDS);

    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

    logic              dbit;
    logic              dbit_valid;
    state_t            state;
    logic [7:0]        sync_sr;
    logic [DATA_W-1:0] word_sr;
    logic [BW-1:0]     bit_cnt;
    logic [WW-1:0]     word_cnt;
    logic [7:0]        sync_next;
    logic [DATA_W-1:0] word_next;
    logic              accept;

    tff_bit_decoder u_bit_decoder (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_q     (bus.line_q),
        .bit_en     (bus.bit_en),
        .dbit       (dbit),
        .dbit_valid (dbit_valid)
    );

    assign sync_next = {sync_sr[6:0], dbit};
    assign word_next = {dbit, word_sr[DATA_W-1:1]};
    assign accept    = bus.data_out_valid & bus.out_ready;

    // A completing word may load into the holding register only if it is
    // empty or being drained this very cycle; otherwise it is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= HUNT;
            sync_sr            <= '0;
            word_sr            <= '0;
            bit_cnt            <= '0;
            word_cnt           <= '0;
            bus.data_out       <= '0;
            bus.data_out_valid <= 1'b0;
            bus.sync_locked    <= 1'b0;
            bus.overrun        <= 1'b0;
            bus.frame_done     <= 1'b0;
        end else begin
            bus.overrun    <= 1'b0;
            bus.frame_done <= 1'b0;
            if (accept) begin
                bus.data_out_valid <= 1'b0;
            end

            case (state)
                HUNT: begin
                    if (dbit_valid) begin
                        sync_sr <= sync_next;
                        if (sync_next == SYNC_PAT) begin
                            state           <= DATA;
                            bit_cnt         <= '0;
                            word_cnt        <= '0;
                            bus.sync_locked <= 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (dbit_valid) begin
                        word_sr <= word_next;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (!bus.data_out_valid || accept) begin
                                bus.data_out       <= word_next;
                                bus.data_out_valid <= 1'b1;
                            end else begin
                                bus.overrun <= 1'b1;
                            end
                            if (word_cnt == WORD_LAST) begin
                                bus.frame_done  <= 1'b1;
                                bus.sync_locked <= 1'b0;
                                state           <= HUNT;
                                sync_sr         <= '0;
                                word_cnt        <= '0;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_tff_stream_decoder.sv
// Bench for tff_stream_decoder: encodes bits as line toggles, scoreboards
// delivered words against the words sent, and probes handshake corner cases.
module tb_tff_stream_decoder;
    import tff_stream_pkg::*;

    localparam logic [7:0] SYNC = 8'h7E;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic level;
    int testsRun = 0;
    int testsFailed = 0;
    int overrunCnt = 0;
    int frameCnt = 0;
    logic [7:0] gotQ[$];
    logic [7:0] expQ[$];
    logic [7:0] w;

    tff_stream_decoder_if #(.DATA_W(8)) bus ();

    tff_stream_decoder #(
        .DATA_W      (8),
        .SYNC_PAT    (8'h7E),
        .FRAME_WORDS (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Transfers become visible at the falling edge preceding the accepting clock.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.data_out_valid && bus.out_ready) gotQ.push_back(bus.data_out);
            if (bus.overrun) overrunCnt++;
            if (bus.frame_done) frameCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic b, input int gap, input logic raiseReady);
        if (b) level = ~level;
        bus.line_q = level;
        bus.bit_en = 1'b1;
        if (raiseReady) bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_en = 1'b0;
        repeat (gap) begin
            bus.line_q = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.line_q = level;
    endtask

    task automatic sendSync();
        repeat (8) applyStimulus(1'b0, int'($urandom_range(2, 0)), 1'b0);
        for (int i = 7; i >= 1; i--) applyStimulus(SYNC[i], int'($urandom_range(2, 0)), 1'b0);
        checkOutput("lock_before_last", 32'(bus.sync_locked), 32'd0);
        applyStimulus(SYNC[0], 0, 1'b0);
        checkOutput("lock_after_sync", 32'(bus.sync_locked), 32'd1);
    endtask

    task automatic sendWord(input logic [7:0] data, input int gapMax, input logic raiseReady);
        for (int i = 0; i < 8; i++)
            applyStimulus(data[i], (i == 7) ? 0 : int'($urandom_range(gapMax, 0)), raiseReady && (i == 7));
    endtask

    task automatic checkQueue(input string tag);
        checkOutput($sformatf("%s_count", tag), 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
            checkOutput($sformatf("%s_word%0d", tag, i), 32'(gotQ[i]), 32'(expQ[i]));
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_data"}, 32'(bus.data_out), 32'd0);
        checkOutput({tag, "_valid"}, 32'(bus.data_out_valid), 32'd0);
        checkOutput({tag, "_lock"}, 32'(bus.sync_locked), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    endtask

    initial begin
        bus.line_q = 1'b0;
        bus.bit_en = 1'b0;
        bus.out_ready = 1'b0;
        level = 1'b0;

        // Reset held while the inputs thrash
        repeat (10) begin
            bus.line_q = 1'($urandom);
            bus.bit_en = 1'($urandom);
            @(posedge clk);
            #1;
        end
        checkZero("reset");
        bus.bit_en = 1'b0;
        bus.line_q = 1'b0;
        level = 1'b0;
        reset_n = 1'b1;
        idle(1);

        // Constant line decodes to zeros and never locks
        repeat (12) applyStimulus(1'b0, int'($urandom_range(2, 0)), 1'b0);
        checkOutput("idle_lock", 32'(bus.sync_locked), 32'd0);
        checkOutput("idle_valid", 32'(bus.data_out_valid), 32'd0);

        // Sync then 0xA5 with one-clock output latency
        bus.out_ready = 1'b1;
        sendSync();
        sendWord(8'hA5, 2, 1'b0);
        checkOutput("a5_valid", 32'(bus.data_out_valid), 32'd1);
        checkOutput("a5_data", 32'(bus.data_out), 32'hA5);
        expQ.push_back(8'hA5);
        idle(1);
        checkOutput("a5_drained", 32'(bus.data_out_valid), 32'd0);
        repeat (3) begin
            w = 8'($urandom);
            expQ.push_back(w);
            sendWord(w, 2, 1'b0);
        end
        idle(3);
        checkQueue("first_frame");

        // Full frame 01..04, frame_done coincides with the last word
        frameCnt = 0;
        sendSync();
        for (int i = 1; i <= 3; i++) begin
            sendWord(8'(i), 3, 1'b0);
            expQ.push_back(8'(i));
        end
        sendWord(8'h04, 3, 1'b0);
        expQ.push_back(8'h04);
        checkOutput("frame_done_pulse", 32'(bus.frame_done), 32'd1);
        checkOutput("frame_last_data", 32'(bus.data_out), 32'h04);
        checkOutput("frame_last_valid", 32'(bus.data_out_valid), 32'd1);
        checkOutput("frame_unlock", 32'(bus.sync_locked), 32'd0);
        idle(1);
        checkOutput("frame_done_once", 32'(bus.frame_done), 32'd0);
        idle(2);
        checkQueue("full_frame");
        checkOutput("full_frame_count", 32'(frameCnt), 32'd1);

        // Backpressure: 22 is dropped while 11 waits
        overrunCnt = 0;
        frameCnt = 0;
        bus.out_ready = 1'b0;
        sendSync();
        sendWord(8'h11, 2, 1'b0);
        idle(2);
        sendWord(8'h22, 2, 1'b0);
        checkOutput("bp_overrun", 32'(bus.overrun), 32'd1);
        checkOutput("bp_hold_data", 32'(bus.data_out), 32'h11);
        checkOutput("bp_hold_valid", 32'(bus.data_out_valid), 32'd1);
        idle(1);
        checkOutput("bp_overrun_pulse", 32'(bus.overrun), 32'd0);
        bus.out_ready = 1'b1;
        idle(2);
        sendWord(8'h33, 2, 1'b0);
        checkOutput("bp_next_data", 32'(bus.data_out), 32'h33);
        sendWord(8'h44, 2, 1'b0);
        idle(3);
        expQ.push_back(8'h11);
        expQ.push_back(8'h33);
        expQ.push_back(8'h44);
        checkQueue("backpressure");
        checkOutput("bp_overrun_count", 32'(overrunCnt), 32'd1);
        checkOutput("bp_frame_count", 32'(frameCnt), 32'd1);

        // Accept of the old word in the same cycle the next word completes
        overrunCnt = 0;
        bus.out_ready = 1'b0;
        sendSync();
        sendWord(8'h55, 2, 1'b0);
        idle(1);
        sendWord(8'h66, 2, 1'b1);
        checkOutput("simul_data", 32'(bus.data_out), 32'h66);
        checkOutput("simul_valid", 32'(bus.data_out_valid), 32'd1);
        checkOutput("simul_overrun", 32'(bus.overrun), 32'd0);
        sendWord(8'h77, 2, 1'b0);
        sendWord(8'h88, 2, 1'b0);
        idle(3);
        expQ = '{8'h55, 8'h66, 8'h77, 8'h88};
        checkQueue("simultaneous");
        checkOutput("simul_overrun_count", 32'(overrunCnt), 32'd0);

        // Reset three bits into word 2, then a clean frame
        frameCnt = 0;
        sendSync();
        w = 8'($urandom);
        expQ.push_back(w);
        sendWord(w, 2, 1'b0);
        w = 8'($urandom);
        for (int i = 0; i < 3; i++) applyStimulus(w[i], 1, 1'b0);
        reset_n = 1'b0;
        #1;
        checkZero("midreset");
        level = 1'b0;
        bus.line_q = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        sendSync();
        repeat (4) begin
            w = 8'($urandom);
            expQ.push_back(w);
            sendWord(w, 2, 1'b0);
        end
        idle(3);
        checkQueue("after_reset");
        checkOutput("after_reset_frames", 32'(frameCnt), 32'd1);

        // Randomized frames with random strobe spacing, including back-to-back strobes
        frameCnt = 0;
        overrunCnt = 0;
        repeat (3) begin
            sendSync();
            repeat (4) begin
                w = 8'($urandom);
                expQ.push_back(w);
                sendWord(w, 3, 1'b0);
            end
            idle(2);
        end
        checkQueue("random");
        checkOutput("random_frames", 32'(frameCnt), 32'd3);
        checkOutput("random_overruns", 32'(overrunCnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
